// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with register file, hazard detection, branch resolution and ID/EX register.
module id_stage #(
    parameter int DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_pc_4,
    input  logic [31:0] id_instruction,
    input  logic        wb_regWrite,
    input  logic [4:0]  wb_writeRegAddr,
    input  logic [31:0] wb_writeRegData,
    input  logic        ex_memRead_in,
    input  logic        ex_regWrite_in,
    input  logic [4:0]  ex_writeRegAddr_in,
    input  logic        mem_memRead,
    input  logic        mem_regWrite,
    input  logic [4:0]  mem_writeRegAddr,
    input  logic [31:0] mem_aluOut,
    output logic        id_shouldStall,
    output logic        id_shouldJumpOrBranch,
    output logic [31:0] id_jumpOrBranchPc,
    output logic        id_flush,
    output logic [31:0] ex_pc_4,
    output logic [31:0] ex_rdataA,
    output logic [31:0] ex_rdataB,
    output logic [31:0] ex_imm32,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_writeRegAddr,
    output logic [3:0]  ex_aluOp,
    output logic        ex_aluSrcB,
    output logic        ex_regWrite,
    output logic        ex_memRead,
    output logic        ex_memWrite,
    output logic [1:0]  ex_wbSel
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                           ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_LUI = 4'd9;

    logic [31:0] rf [32];
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext, imm32, rdata_a, rdata_b, cmp_a, cmp_b;
    logic [4:0]  wa;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic valid, src_b, reg_write, mem_read, mem_write, uses_rs, uses_rt, zext, shift;
    logic is_j, is_jal, is_jr, is_beq, is_bne, is_br, taken, ex_hit, mem_hit;

    assign {opc, rs, rt, rd, shamt, fn} = id_instruction;
    assign imm = id_instruction[15:0];
    assign sext = {{16{imm[15]}}, imm};

    always_comb begin
        valid = 1'b1;
        alu_op = ALU_ADD;
        src_b = 1'b0;
        reg_write = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        wb_sel = 2'd0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        zext = 1'b0;
        shift = 1'b0;
        is_j = 1'b0;
        is_jal = 1'b0;
        is_jr = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        if (opc == 6'h00) begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            reg_write = 1'b1;
            case (fn)
                6'h20, 6'h21: alu_op = ALU_ADD;
                6'h22, 6'h23: alu_op = ALU_SUB;
                6'h24: alu_op = ALU_AND;
                6'h25: alu_op = ALU_OR;
                6'h26: alu_op = ALU_XOR;
                6'h27: alu_op = ALU_NOR;
                6'h2a: alu_op = ALU_SLT;
                6'h00: begin alu_op = ALU_SLL; uses_rs = 1'b0; shift = 1'b1; end
                6'h02: begin alu_op = ALU_SRL; uses_rs = 1'b0; shift = 1'b1; end
                6'h08: begin is_jr = 1'b1; uses_rt = 1'b0; reg_write = 1'b0; end
                default: begin valid = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; reg_write = 1'b0; end
            endcase
        end else begin
            case (opc)
                6'h08: begin alu_op = ALU_ADD; src_b = 1'b1; reg_write = 1'b1; uses_rs = 1'b1; end
                6'h0c: begin alu_op = ALU_AND; src_b = 1'b1; reg_write = 1'b1; uses_rs = 1'b1; zext = 1'b1; end
                6'h0d: begin alu_op = ALU_OR;  src_b = 1'b1; reg_write = 1'b1; uses_rs = 1'b1; zext = 1'b1; end
                6'h0e: begin alu_op = ALU_XOR; src_b = 1'b1; reg_write = 1'b1; uses_rs = 1'b1; zext = 1'b1; end
                6'h0a: begin alu_op = ALU_SLT; src_b = 1'b1; reg_write = 1'b1; uses_rs = 1'b1; end
                6'h0f: begin alu_op = ALU_LUI; src_b = 1'b1; reg_write = 1'b1; zext = 1'b1; end
                6'h23: begin src_b = 1'b1; reg_write = 1'b1; mem_read = 1'b1; wb_sel = 2'd1; uses_rs = 1'b1; end
                6'h2b: begin src_b = 1'b1; mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                6'h04: begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                6'h05: begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                6'h02: is_j = 1'b1;
                6'h03: begin is_jal = 1'b1; reg_write = 1'b1; wb_sel = 2'd2; end
                default: valid = 1'b0;
            endcase
        end
    end

    assign imm32 = shift ? {27'd0, shamt} : zext ? {16'd0, imm} : sext;
    assign wa = is_jal ? 5'd31 : (opc == 6'h00) ? rd : rt;

    // Same-cycle write-back bypass so WB and ID can share a cycle.
    assign rdata_a = (rs == 5'd0) ? 32'd0 : (wb_regWrite && wb_writeRegAddr == rs) ? wb_writeRegData : rf[rs];
    assign rdata_b = (rt == 5'd0) ? 32'd0 : (wb_regWrite && wb_writeRegAddr == rt) ? wb_writeRegData : rf[rt];

    // Branch/jr operands may take a finished ALU result from MEM; load data there forces a stall instead.
    assign cmp_a = (mem_regWrite && !mem_memRead && mem_writeRegAddr != 5'd0 && mem_writeRegAddr == rs) ? mem_aluOut : rdata_a;
    assign cmp_b = (mem_regWrite && !mem_memRead && mem_writeRegAddr != 5'd0 && mem_writeRegAddr == rt) ? mem_aluOut : rdata_b;

    assign is_br = is_beq || is_bne || is_jr;
    assign ex_hit = ex_writeRegAddr_in != 5'd0 &&
                    ((uses_rs && ex_writeRegAddr_in == rs) || (uses_rt && ex_writeRegAddr_in == rt));
    assign mem_hit = mem_writeRegAddr != 5'd0 &&
                     ((uses_rs && mem_writeRegAddr == rs) || (uses_rt && mem_writeRegAddr == rt));
    assign id_shouldStall = !rst && ((ex_memRead_in && ex_hit) || (is_br && ex_regWrite_in && ex_hit) ||
                                     (is_br && mem_memRead && mem_hit));

    assign taken = is_j || is_jal || is_jr || (is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b);
    assign id_shouldJumpOrBranch = !rst && !id_shouldStall && taken;
    assign id_jumpOrBranchPc = is_jr ? cmp_a :
                               (is_j || is_jal) ? {id_pc_4[31:28], id_instruction[25:0], 2'b00} :
                               id_pc_4 + {sext[29:0], 2'b00};
    assign id_flush = id_shouldJumpOrBranch && (DELAY_SLOT == 0);

    always_ff @(posedge clk) begin
        if (rst)
            rf <= '{default: '0};
        else if (wb_regWrite && wb_writeRegAddr != 5'd0)
            rf[wb_writeRegAddr] <= wb_writeRegData;
    end

    always_ff @(posedge clk) begin
        if (rst || id_shouldStall || !valid) begin
            ex_pc_4 <= '0;
            ex_rdataA <= '0;
            ex_rdataB <= '0;
            ex_imm32 <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            ex_writeRegAddr <= '0;
            ex_aluOp <= '0;
            ex_aluSrcB <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_memRead <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_wbSel <= '0;
        end else begin
            ex_pc_4 <= id_pc_4;
            ex_rdataA <= rdata_a;
            ex_rdataB <= rdata_b;
            ex_imm32 <= imm32;
            ex_rs <= rs;
            ex_rt <= rt;
            ex_writeRegAddr <= wa;
            ex_aluOp <= alu_op;
            ex_aluSrcB <= src_b;
            ex_regWrite <= reg_write;
            ex_memRead <= mem_read;
            ex_memWrite <= mem_write;
            ex_wbSel <= wb_sel;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table-driven mnemonic model checked every cycle plus directed literal scenarios.
module tb_id_stage;
    localparam int DS = 1;
    localparam int K_BAD = 0, K_ADD = 1, K_ADDU = 2, K_SUB = 3, K_SUBU = 4, K_AND = 5, K_OR = 6, K_XOR = 7,
                   K_NOR = 8, K_SLT = 9, K_SLL = 10, K_SRL = 11, K_JR = 12, K_ADDI = 13, K_ANDI = 14,
                   K_ORI = 15, K_XORI = 16, K_SLTI = 17, K_LUI = 18, K_LW = 19, K_SW = 20, K_BEQ = 21,
                   K_BNE = 22, K_J = 23, K_JAL = 24;
    //                               BAD ADD ADU SUB SBU AND OR XOR NOR SLT SLL SRL JR ADI ANI ORI XRI SLI LUI LW SW BEQ BNE J JAL
    localparam int ALU_T [25] = '{-1,  0,  0,  1,  1,  2,  3,  4,  5,  6,  7,  8, -1, 0,  2,  3,  4,  6,  9,  0, 0, -1, -1, -1, -1};
    localparam int RW_T  [25] = '{ 0,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  0, 1,  1,  1,  1,  1,  1,  1, 0,  0,  0,  0,  1};
    localparam int WB_T  [25] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0,  0,  0,  0,  0,  0,  1, 0,  0,  0,  0,  2};
    localparam int DST_T [25] = '{-1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1,  1,  1,  1,  1,  1,  1, 1,  1,  1, -1,  2};
    localparam int EXT_T [25] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  3,  3,  0, 1,  2,  2,  2,  1,  0,  1, 1,  1,  1,  0,  0};
    localparam int UR_T  [25] = '{ 0,  1,  1,  1,  1,  1,  1,  1,  1,  1,  0,  0,  1, 1,  1,  1,  1,  1,  0,  1, 1,  1,  1,  0,  0};
    localparam int UT_T  [25] = '{ 0,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  0, 0,  0,  0,  0,  0,  0,  0, 1,  1,  1,  0,  0};

    logic clk = 0, rst = 1;
    logic [31:0] id_pc_4 = 0, id_instruction = 0, wb_writeRegData = 0, mem_aluOut = 0;
    logic wb_regWrite = 0, ex_memRead_in = 0, ex_regWrite_in = 0, mem_memRead = 0, mem_regWrite = 0;
    logic [4:0] wb_writeRegAddr = 0, ex_writeRegAddr_in = 0, mem_writeRegAddr = 0;
    logic id_shouldStall, id_shouldJumpOrBranch, id_flush, ex_aluSrcB, ex_regWrite, ex_memRead, ex_memWrite;
    logic [31:0] id_jumpOrBranchPc, ex_pc_4, ex_rdataA, ex_rdataB, ex_imm32;
    logic [4:0] ex_rs, ex_rt, ex_writeRegAddr;
    logic [3:0] ex_aluOp;
    logic [1:0] ex_wbSel;
    int checks = 0, errors = 0;

    id_stage #(.DELAY_SLOT(DS)) dut (
        .clk(clk), .rst(rst), .id_pc_4(id_pc_4), .id_instruction(id_instruction),
        .wb_regWrite(wb_regWrite), .wb_writeRegAddr(wb_writeRegAddr), .wb_writeRegData(wb_writeRegData),
        .ex_memRead_in(ex_memRead_in), .ex_regWrite_in(ex_regWrite_in), .ex_writeRegAddr_in(ex_writeRegAddr_in),
        .mem_memRead(mem_memRead), .mem_regWrite(mem_regWrite), .mem_writeRegAddr(mem_writeRegAddr),
        .mem_aluOut(mem_aluOut), .id_shouldStall(id_shouldStall), .id_shouldJumpOrBranch(id_shouldJumpOrBranch),
        .id_jumpOrBranchPc(id_jumpOrBranchPc), .id_flush(id_flush), .ex_pc_4(ex_pc_4), .ex_rdataA(ex_rdataA),
        .ex_rdataB(ex_rdataB), .ex_imm32(ex_imm32), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_writeRegAddr(ex_writeRegAddr), .ex_aluOp(ex_aluOp), .ex_aluSrcB(ex_aluSrcB),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_wbSel(ex_wbSel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        if (ins[31:26] == 6'h00)
            case (ins[5:0])
                6'h20: return K_ADD;  6'h21: return K_ADDU; 6'h22: return K_SUB; 6'h23: return K_SUBU;
                6'h24: return K_AND;  6'h25: return K_OR;   6'h26: return K_XOR; 6'h27: return K_NOR;
                6'h2a: return K_SLT;  6'h00: return K_SLL;  6'h02: return K_SRL; 6'h08: return K_JR;
                default: return K_BAD;
            endcase
        case (ins[31:26])
            6'h08: return K_ADDI; 6'h0c: return K_ANDI; 6'h0d: return K_ORI; 6'h0e: return K_XORI;
            6'h0a: return K_SLTI; 6'h0f: return K_LUI;  6'h23: return K_LW;  6'h2b: return K_SW;
            6'h04: return K_BEQ;  6'h05: return K_BNE;  6'h02: return K_J;   6'h03: return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    logic [31:0] m_rf [32];
    logic [31:0] m_ins, m_pc4, m_a, m_b;
    int m_k;
    bit m_rst, m_bub, chk_en = 0;

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 0) return 0;
        if (wb_regWrite && wb_writeRegAddr == a) return wb_writeRegData;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (mem_regWrite && !mem_memRead && a != 0 && mem_writeRegAddr == a) return mem_aluOut;
        return rd_reg(a);
    endfunction

    function automatic bit hit(input int k, input logic [4:0] d);
        return d != 0 && ((UR_T[k] != 0 && d == id_instruction[25:21]) || (UT_T[k] != 0 && d == id_instruction[20:16]));
    endfunction

    function automatic void model_comb(output bit st, output bit jb, output logic [31:0] tgt);
        int k;
        bit br;
        logic [31:0] a, b;
        logic signed [15:0] s16;
        k = kind_of(id_instruction);
        br = (k == K_BEQ || k == K_BNE || k == K_JR);
        a = opnd(id_instruction[25:21]);
        b = opnd(id_instruction[20:16]);
        s16 = id_instruction[15:0];
        st = !rst && ((ex_memRead_in && hit(k, ex_writeRegAddr_in)) || (br && ex_regWrite_in && hit(k, ex_writeRegAddr_in)) ||
                      (br && mem_memRead && hit(k, mem_writeRegAddr)));
        jb = !rst && !st && (k == K_J || k == K_JAL || k == K_JR || (k == K_BEQ && a == b) || (k == K_BNE && a != b));
        tgt = (k == K_JR) ? a : (k == K_J || k == K_JAL) ? {id_pc_4[31:28], id_instruction[25:0], 2'b00} :
              id_pc_4 + 32'(int'(s16) * 4);
    endfunction

    always @(posedge clk) begin : mdl
        bit st, jb;
        logic [31:0] t;
        model_comb(st, jb, t);
        m_rst = rst;
        m_k = kind_of(id_instruction);
        m_bub = rst || st || m_k == K_BAD;
        m_ins = id_instruction;
        m_pc4 = id_pc_4;
        m_a = rd_reg(id_instruction[25:21]);
        m_b = rd_reg(id_instruction[20:16]);
        if (rst) m_rf = '{default: 0};
        else if (wb_regWrite && wb_writeRegAddr != 0) m_rf[wb_writeRegAddr] = wb_writeRegData;
        chk_en = 1;
    end

    always @(negedge clk) begin : cmp
        bit st, jb;
        logic [31:0] t;
        logic signed [15:0] s16;
        if (chk_en) begin
            model_comb(st, jb, t);
            chk("stall", id_shouldStall, st);
            chk("jump", id_shouldJumpOrBranch, jb);
            chk("flush", id_flush, jb && DS == 0);
            if (jb) chk("target", id_jumpOrBranchPc, t);
            if (m_bub) begin
                chk("bub_regWrite", ex_regWrite, 0);
                chk("bub_memRead", ex_memRead, 0);
                chk("bub_memWrite", ex_memWrite, 0);
                chk("bub_wbSel", ex_wbSel, 0);
                chk("bub_aluOp", ex_aluOp, 0);
                chk("bub_aluSrcB", ex_aluSrcB, 0);
                if (m_rst) begin
                    chk("rst_pc_4", ex_pc_4, 0);
                    chk("rst_rdataA", ex_rdataA, 0);
                    chk("rst_rdataB", ex_rdataB, 0);
                    chk("rst_imm32", ex_imm32, 0);
                    chk("rst_rs", ex_rs, 0);
                    chk("rst_rt", ex_rt, 0);
                    chk("rst_wa", ex_writeRegAddr, 0);
                end
            end else begin
                chk("ex_pc_4", ex_pc_4, m_pc4);
                chk("ex_rdataA", ex_rdataA, m_a);
                chk("ex_rdataB", ex_rdataB, m_b);
                chk("ex_rs", ex_rs, m_ins[25:21]);
                chk("ex_rt", ex_rt, m_ins[20:16]);
                chk("ex_regWrite", ex_regWrite, RW_T[m_k]);
                chk("ex_memRead", ex_memRead, m_k == K_LW);
                chk("ex_memWrite", ex_memWrite, m_k == K_SW);
                if (RW_T[m_k] != 0) chk("ex_wbSel", ex_wbSel, WB_T[m_k]);
                if (ALU_T[m_k] >= 0) begin
                    chk("ex_aluOp", ex_aluOp, ALU_T[m_k]);
                    chk("ex_aluSrcB", ex_aluSrcB, m_k >= K_ADDI && m_k <= K_SW);
                end
                if (DST_T[m_k] >= 0)
                    chk("ex_wa", ex_writeRegAddr, DST_T[m_k] == 0 ? m_ins[15:11] : DST_T[m_k] == 1 ? m_ins[20:16] : 5'd31);
                s16 = m_ins[15:0];
                if (EXT_T[m_k] != 0)
                    chk("ex_imm32", ex_imm32, EXT_T[m_k] == 1 ? 32'(int'(s16)) : EXT_T[m_k] == 2 ? 32'(m_ins[15:0]) : 32'(m_ins[10:6]));
            end
        end
    end

    logic [31:0] v_ins [20] = '{32'h00221820, 32'h00222022, 32'h20A6FFFF, 32'h34A78000, 32'h00E31100,
                                32'h8CA80000, 32'hACA80004, 32'h3C011234, 32'h010A5826, 32'h00286027,
                                32'h290D0005, 32'h000877C2, 32'hFC000000, 32'h0022183F, 32'h310FFFFF,
                                32'h1422FFFE, 32'h1028FFFE, 32'h08000010, 32'h01000008, 32'h010A802A};
    logic [4:0]  v_wa [20] = '{1, 2, 4, 8, 10, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] v_wd [20] = '{32'h55, 32'h55, 32'h7, 32'hA5A50000, 32'h3, 32'hDEADBEEF, 32'h99, 0, 0, 0,
                                0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wb_regWrite = 0; wb_writeRegAddr = 0; wb_writeRegData = 0;
        ex_memRead_in = 0; ex_regWrite_in = 0; ex_writeRegAddr_in = 0;
        mem_memRead = 0; mem_regWrite = 0; mem_writeRegAddr = 0; mem_aluOut = 0;
    endtask

    task automatic set_ex(input logic mr, input logic rw, input logic [4:0] a);
        ex_memRead_in = mr; ex_regWrite_in = rw; ex_writeRegAddr_in = a;
    endtask

    initial begin
        // rst masks hazard and jump outputs even with a stalling jr present
        id_instruction = 32'h00A00008;
        set_ex(1, 1, 5);
        #3;
        chk("lit_rst_stall", id_shouldStall, 0);
        chk("lit_rst_jump", id_shouldJumpOrBranch, 0);
        chk("lit_rst_flush", id_flush, 0);
        tick();
        chk("lit_rst_regWrite", ex_regWrite, 0);
        chk("lit_rst_pc_4", ex_pc_4, 0);
        rst = 0;
        clr();
        for (int i = 0; i < 20; i++) begin
            id_instruction = v_ins[i];
            id_pc_4 = 32'h0040_0000 + 32'(i * 4);
            wb_regWrite = 1; wb_writeRegAddr = v_wa[i]; wb_writeRegData = v_wd[i];
            tick();
        end
        clr();
        id_instruction = 32'h00A01820;
        id_pc_4 = 32'h104;
        wb_regWrite = 1; wb_writeRegAddr = 5; wb_writeRegData = 32'h1234;
        tick(); #2;
        chk("lit_wt_rdataA", ex_rdataA, 32'h1234);
        chk("lit_wt_wa", ex_writeRegAddr, 3);
        id_instruction = 32'h00001820;
        wb_writeRegAddr = 0; wb_writeRegData = 32'hDEADBEEF;
        tick(); #2;
        chk("lit_r0_rdataA", ex_rdataA, 0);
        clr();
        id_instruction = 32'h010A4820;
        set_ex(1, 1, 8);
        #1;
        chk("lit_lu_stall", id_shouldStall, 1);
        tick(); #2;
        chk("lit_lu_bubble", ex_regWrite, 0);
        set_ex(0, 0, 0);
        tick(); #2;
        chk("lit_lu_wa", ex_writeRegAddr, 9);
        chk("lit_lu_regWrite", ex_regWrite, 1);
        chk("lit_lu_rdataA", ex_rdataA, 32'hA5A50000);
        id_instruction = 32'h10220004;
        id_pc_4 = 32'h100;
        #1;
        chk("lit_beq_jump", id_shouldJumpOrBranch, 1);
        chk("lit_beq_pc", id_jumpOrBranchPc, 32'h110);
        chk("lit_beq_flush", id_flush, 0);
        tick();
        id_instruction = 32'h0C000040;
        id_pc_4 = 32'h10000008;
        #1;
        chk("lit_jal_pc", id_jumpOrBranchPc, 32'h10000100);
        chk("lit_jal_jump", id_shouldJumpOrBranch, 1);
        tick(); #2;
        chk("lit_jal_wa", ex_writeRegAddr, 31);
        chk("lit_jal_wbSel", ex_wbSel, 2);
        chk("lit_jal_pc_4", ex_pc_4, 32'h10000008);
        chk("lit_jal_regWrite", ex_regWrite, 1);
        id_instruction = 32'h14800008;
        id_pc_4 = 32'h200;
        mem_regWrite = 1; mem_writeRegAddr = 4; mem_aluOut = 0;
        #1;
        chk("lit_mf_jump", id_shouldJumpOrBranch, 0);
        chk("lit_mf_stall", id_shouldStall, 0);
        tick();
        mem_regWrite = 0;
        #1;
        chk("lit_nofwd_jump", id_shouldJumpOrBranch, 1);
        tick();
        clr();
        id_instruction = 32'h10220004;
        set_ex(0, 1, 2);
        #1;
        chk("lit_br_ex_stall", id_shouldStall, 1);
        chk("lit_br_ex_jump", id_shouldJumpOrBranch, 0);
        tick();
        clr();
        mem_memRead = 1; mem_regWrite = 1; mem_writeRegAddr = 1;
        #1;
        chk("lit_br_mem_stall", id_shouldStall, 1);
        tick();
        clr();
        id_instruction = 32'h01000008;
        set_ex(0, 1, 8);
        #1;
        chk("lit_jr_stall", id_shouldStall, 1);
        tick();
        id_instruction = 32'h20A6FFFF;
        set_ex(1, 1, 6);
        #1;
        chk("lit_addi_rt_nostall", id_shouldStall, 0);
        tick();
        id_instruction = 32'h00E31100;
        set_ex(1, 1, 7);
        #1;
        chk("lit_sll_rs_nostall", id_shouldStall, 0);
        tick();
        id_instruction = 32'h010A4820;
        set_ex(0, 1, 8);
        #1;
        chk("lit_alu_ex_nostall", id_shouldStall, 0);
        tick();
        id_instruction = 32'h00001820;
        set_ex(1, 1, 0);
        #1;
        chk("lit_r0_nostall", id_shouldStall, 0);
        tick();
        clr();
        id_instruction = 32'h00A01820;
        id_pc_4 = 32'h300;
        rst = 1;
        tick(); #2;
        chk("lit_mid_rst_pc_4", ex_pc_4, 0);
        chk("lit_mid_rst_rdataA", ex_rdataA, 0);
        chk("lit_mid_rst_wa", ex_writeRegAddr, 0);
        rst = 0;
        tick(); #2;
        chk("lit_mid_rst_r5", ex_rdataA, 0);
        chk("lit_mid_rst_issue", ex_regWrite, 1);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DELAY_SLOT, default 1: fetched instruction after a taken branch/jump executes; 0 drives id_flush high for that cycle.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_pc_4  input  32 and id_instruction  input  32, both from the IF/ID registers.
REQ-005 SHALL have ports wb_regWrite  input  1, wb_writeRegAddr  input  5 and wb_writeRegData  input  32, the register-file write port.
REQ-006 SHALL have ports ex_memRead_in  input  1, ex_regWrite_in  input  1 and ex_writeRegAddr_in  input  5, the current EX-stage destination.
REQ-007 SHALL have ports mem_memRead  input  1, mem_regWrite  input  1, mem_writeRegAddr  input  5 and mem_aluOut  input  32, the MEM-stage destination and result.
REQ-008 SHALL have ports id_shouldStall  output  1, id_shouldJumpOrBranch  output  1, id_jumpOrBranchPc  output  32 and id_flush  output  1.
REQ-009 SHALL have registered ID/EX outputs: ex_pc_4 32, ex_rdataA 32, ex_rdataB 32, ex_imm32 32, ex_rs 5, ex_rt 5, ex_writeRegAddr 5, ex_aluOp 4, ex_aluSrcB 1, ex_regWrite 1, ex_memRead 1, ex_memWrite 1, ex_wbSel 2.

Function
REQ-010 SHALL contain a 32x32 register file: $0 reads 0, writes to $0 ignored, write on clk edge when wb_regWrite.
REQ-011 SHALL bypass reads: when wb_regWrite and wb_writeRegAddr equals a nonzero source address, the read returns wb_writeRegData in the same cycle.
REQ-012 SHALL decode add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, jr, addi, andi, ori, xori, slti, lui, lw, sw, beq, bne, j, jal; any other opcode or funct SHALL issue a bubble.
REQ-013 SHALL use ex_aluOp encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 LUI.
REQ-014 SHALL use ex_wbSel 0 ALU, 1 memory, 2 pc_4.
REQ-015 SHALL sign-extend imm16 for addi, slti, lw, sw, beq and bne, and zero-extend it for andi, ori and xori.
REQ-016 SHALL place shamt zero-extended in ex_imm32 for sll and srl.
REQ-017 SHALL set ex_writeRegAddr to rd for R-type, rt for I-type and 31 for jal; jal SHALL drive ex_wbSel=2 with ex_regWrite=1.
REQ-018 SHALL resolve branches in ID: target = id_pc_4 + (sign-extended imm16 << 2), 32-bit wrap-around.
REQ-019 SHALL compute j/jal target as {id_pc_4[31:28], instr[25:0], 2'b00} and jr target as the rs value.
REQ-020 SHALL forward mem_aluOut to the branch/jr comparison operands when mem_regWrite, !mem_memRead and mem_writeRegAddr is a nonzero matching source.
REQ-021 SHALL assert id_shouldStall combinationally on any of the following, each with a nonzero matching destination: (a) ex_memRead_in and EX destination equal to a used rs/rt; (b) current instruction is beq/bne/jr and ex_regWrite_in with EX destination equal to a used source; (c) current instruction is beq/bne/jr and mem_memRead with MEM destination equal to a used source.
REQ-022 SHALL never stall on operands the instruction does not use, e.g. rt of addi or rs of sll.
REQ-023 SHALL, while stalled, load a bubble into ID/EX (all control outputs 0, data outputs don't-care) and hold id_shouldJumpOrBranch at 0; register-file writes SHALL proceed.
REQ-024 SHALL drive id_shouldJumpOrBranch high combinationally when not stalled and the instruction is j, jal, jr, taken beq or taken bne; id_flush = id_shouldJumpOrBranch && DELAY_SLOT==0.
REQ-025 SHALL, when not stalled, load all ID/EX outputs on each clk edge with latency 1 cycle.

Reset
REQ-026 SHALL, on a clk edge with rst=1, clear all 32 registers and all ID/EX outputs to 0 (a bubble); rst SHALL take priority over stall and write.
REQ-027 SHALL hold id_shouldStall, id_shouldJumpOrBranch and id_flush at 0 while rst=1, regardless of other inputs.

Verification
REQ-028 SHALL pass reset test: rst high one edge mid-stream -> every ex_* output is 0 and a read of $5 returns 0.
REQ-029 SHALL pass write-through test: wb writes $5=0x00001234 while ID decodes add $3,$5,$0 -> ex_rdataA=0x00001234 after the edge; a wb write to $0 leaves $0 reading 0.
REQ-030 SHALL pass load-use test: ex_memRead_in=1, EX destination 8, ID holds add $9,$8,$10 -> id_shouldStall=1 and the next ex_regWrite=0; hazard cleared -> add issues with ex_writeRegAddr=9.
REQ-031 SHALL pass taken-beq test: beq equal operands, imm=4, id_pc_4=0x00000100 -> id_shouldJumpOrBranch=1, id_jumpOrBranchPc=0x00000110, id_flush=0 (DELAY_SLOT=1).
REQ-032 SHALL pass jal test: jal index 0x0000040, id_pc_4=0x10000008 -> id_jumpOrBranchPc=0x10000100, then ex_writeRegAddr=31, ex_wbSel=2, ex_pc_4=0x10000008.
REQ-033 SHALL pass MEM-forward test: bne $4,$0 where mem_regWrite=1, mem_writeRegAddr=4, mem_aluOut=0, regfile $4=7 -> branch not taken, no stall.
